// File: rtl/paddle_motion_ctrl_if.sv
// Control/counter inputs and position/status outputs of one paddle motion controller.
interface paddle_motion_ctrl_if;
  logic        move_up_control;
  logic        move_down_control;
  logic [11:0] col_counter;
  logic [11:0] row_counter;
  logic [11:0] paddle_center_row;
  logic        at_top;
  logic        at_bottom;
  logic        moving;

  modport master (
    output move_up_control, move_down_control, col_counter, row_counter,
    input  paddle_center_row, at_top, at_bottom, moving
  );

  modport slave (
    input  move_up_control, move_down_control, col_counter, row_counter,
    output paddle_center_row, at_top, at_bottom, moving
  );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Per-frame paddle position sequencer: synchronised up/down controls, speed ramp while held,
// and clamping of the paddle center between the top and bottom screen limits.
module paddle_motion_ctrl #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 44,
  parameter int START_ROW     = 240,
  parameter int UPDATE_ROW    = 480,
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_MAX     = 8,
  parameter int ACCEL_FRAMES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  paddle_motion_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam logic [11:0] TOP_LIMIT    = 12'(PADDLE_HEIGHT / 2);
  localparam logic [11:0] BOTTOM_LIMIT = 12'(SCREEN_HEIGHT - 1 - PADDLE_HEIGHT / 2);
  localparam logic [7:0]  SPD_MIN      = 8'(SPEED_MIN);
  localparam logic [7:0]  SPD_MAX      = 8'(SPEED_MAX);
  localparam logic [7:0]  HOLD_LAST    = 8'(ACCEL_FRAMES - 1);

  logic        up_m_q, up_s_q, dn_m_q, dn_s_q;
  logic        match_q, match_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  speed_q, speed_d;
  logic [7:0]  hold_q, hold_d;
  logic [11:0] center_q, center_d;
  logic        at_top_q, at_top_d;
  logic        at_bottom_q, at_bottom_d;
  logic        moving_q, moving_d;

  logic        tick;
  logic        new_move;
  logic        clamp;
  logic [7:0]  spd;
  logic [7:0]  hold_inc;
  logic [7:0]  speed_inc;

  always_comb begin
    match_d     = (bus.row_counter == 12'(UPDATE_ROW)) && (bus.col_counter == '0);
    tick        = match_d & ~match_q;
    state_d     = state_q;
    speed_d     = speed_q;
    hold_d      = hold_q;
    center_d    = center_q;
    at_top_d    = at_top_q;
    at_bottom_d = at_bottom_q;
    moving_d    = moving_q;
    new_move    = 1'b0;
    clamp       = 1'b0;
    spd         = speed_q;
    hold_inc    = hold_q + 8'd1;
    speed_inc   = speed_q + 8'd1;

    if (tick) begin
      case ({up_s_q, dn_s_q})
        2'b10:   state_d = UP;
        2'b01:   state_d = DOWN;
        default: state_d = IDLE;
      endcase

      // A fresh move or reversal steps at minimum speed on this very tick.
      new_move = (state_d != state_q);
      spd      = new_move ? SPD_MIN : speed_q;

      case (state_d)
        UP: begin
          if ({1'b0, center_q} < ({1'b0, TOP_LIMIT} + {5'b0, spd})) begin
            center_d = TOP_LIMIT;
            clamp    = 1'b1;
          end else begin
            center_d = center_q - {4'b0, spd};
          end
        end
        DOWN: begin
          if (({1'b0, center_q} + {5'b0, spd}) > {1'b0, BOTTOM_LIMIT}) begin
            center_d = BOTTOM_LIMIT;
            clamp    = 1'b1;
          end else begin
            center_d = center_q + {4'b0, spd};
          end
        end
        default: center_d = center_q;
      endcase

      if (state_d == IDLE || clamp || new_move) begin
        speed_d = SPD_MIN;
        hold_d  = '0;
      end else if (hold_inc == HOLD_LAST) begin
        hold_d  = '0;
        speed_d = (speed_inc > SPD_MAX) ? SPD_MAX : speed_inc;
      end else begin
        hold_d  = hold_inc;
      end

      at_top_d    = (center_d == TOP_LIMIT);
      at_bottom_d = (center_d == BOTTOM_LIMIT);
      moving_d    = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_m_q      <= 1'b0;
      up_s_q      <= 1'b0;
      dn_m_q      <= 1'b0;
      dn_s_q      <= 1'b0;
      match_q     <= 1'b0;
      state_q     <= IDLE;
      speed_q     <= SPD_MIN;
      hold_q      <= '0;
      center_q    <= 12'(START_ROW);
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      up_m_q      <= bus.move_up_control;
      up_s_q      <= up_m_q;
      dn_m_q      <= bus.move_down_control;
      dn_s_q      <= dn_m_q;
      match_q     <= match_d;
      state_q     <= state_d;
      speed_q     <= speed_d;
      hold_q      <= hold_d;
      center_q    <= center_d;
      at_top_q    <= at_top_d;
      at_bottom_q <= at_bottom_d;
      moving_q    <= moving_d;
    end
  end

  assign bus.paddle_center_row = center_q;
  assign bus.at_top            = at_top_q;
  assign bus.at_bottom         = at_bottom_q;
  assign bus.moving            = moving_q;

endmodule
